// File: rtl/rf_pkg.sv
// Shared constants and types for the integer register file and its scoreboard.
package rf_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam int NREG_RV32E   = 16;
  localparam int NREG_RV32I   = 32;
  localparam int X0           = 0;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for pipelined issue, with flush and bypass-aware read-out.
module rf_scoreboard import rf_pkg::*; #(
  parameter int NREG = NREG_RV32E,
  parameter int AW   = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          active,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic          iss_en,
  input  logic [AW-1:0] iss_addr,
  input  logic          flush,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic          busy1,
  output logic          busy2
);

  // Handshake: iss_en and wr_en are single-cycle strobes with no backpressure;
  // iss_en marks a pending producer, a later wr_en to the same register retires it.
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (wr_en && (32'(wr_addr) == i)) busy_d[i] = 1'b0;
        // Issue is applied after writeback so a new producer wins.
        if (iss_en && (32'(iss_addr) == i)) busy_d[i] = 1'b1;
      end
    end
    busy_d[X0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q <= '0;
    end else if (active) begin
      busy_q <= busy_d;
    end
  end

  function automatic logic lookup(input logic [NREG-1:0] vec, input logic [AW-1:0] a);
    logic hit;
    hit = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      if (32'(a) == i) hit = vec[i];
    end
    return hit;
  endfunction

  assign busy1 = lookup(busy_q, rd_addr1) & ~(wr_en && (wr_addr == rd_addr1));
  assign busy2 = lookup(busy_q, rd_addr2) & ~(wr_en && (wr_addr == rd_addr2));

endmodule

// File: rtl/reg_file_sb.sv
// Two-read/one-write integer register file with x0, bypass, busy scoreboard and post-reset clear.
module reg_file_sb import rf_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NREG = NREG_RV32E,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ready_o,
  input  logic            wr_en_i,
  input  logic [AW-1:0]   wr_addr_i,
  input  logic [XLEN-1:0] wr_data_i,
  input  logic [AW-1:0]   rd_addr1_i,
  input  logic [AW-1:0]   rd_addr2_i,
  output logic [XLEN-1:0] rd_data1_o,
  output logic [XLEN-1:0] rd_data2_o,
  output logic            rd_busy1_o,
  output logic            rd_busy2_o,
  input  logic            iss_en_i,
  input  logic [AW-1:0]   iss_addr_i,
  input  logic            flush_i,
  output rf_state_t       dbg_state
);

  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

  rf_state_t       state_q, state_d;
  logic [IW-1:0]   clr_cnt_q, clr_cnt_d;
  logic            mem_we;
  logic [IW-1:0]   mem_addr;
  logic [XLEN-1:0] mem_data;
  logic            ready;
  logic            busy1, busy2;

  // No per-bit reset: the clear sequencer zeroes x1..xNREG-1 after every reset.
  logic [XLEN-1:0] regs [NREG];

  function automatic logic in_range(input logic [AW-1:0] a);
    return (32'(a) != X0) && (32'(a) < NREG);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= IW'(1);
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = 1'b0;
    mem_addr  = wr_addr_i[IW-1:0];
    mem_data  = wr_data_i;
    case (state_q)
      CLEAR: begin
        mem_we    = reset;
        mem_addr  = clr_cnt_q;
        mem_data  = '0;
        clr_cnt_d = IW'(clr_cnt_q + 1'b1);
        if (clr_cnt_q == IW'(NREG - 1)) state_d = READY;
      end
      READY: begin
        mem_we = reset && wr_en_i && in_range(wr_addr_i);
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) regs[mem_addr] <= mem_data;
  end

  assign ready     = (state_q == READY) && reset;
  assign ready_o   = ready;
  assign dbg_state = state_q;

  always_comb begin
    rd_data1_o = '0;
    if (ready && in_range(rd_addr1_i)) begin
      if (wr_en_i && (wr_addr_i == rd_addr1_i)) rd_data1_o = wr_data_i;
      else                                      rd_data1_o = regs[rd_addr1_i[IW-1:0]];
    end
  end

  always_comb begin
    rd_data2_o = '0;
    if (ready && in_range(rd_addr2_i)) begin
      if (wr_en_i && (wr_addr_i == rd_addr2_i)) rd_data2_o = wr_data_i;
      else                                      rd_data2_o = regs[rd_addr2_i[IW-1:0]];
    end
  end

  rf_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .active   (state_q == READY),
    .wr_en    (wr_en_i),
    .wr_addr  (wr_addr_i),
    .iss_en   (iss_en_i),
    .iss_addr (iss_addr_i),
    .flush    (flush_i),
    .rd_addr1 (rd_addr1_i),
    .rd_addr2 (rd_addr2_i),
    .busy1    (busy1),
    .busy2    (busy2)
  );

  assign rd_busy1_o = ready & busy1;
  assign rd_busy2_o = ready & busy2;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed scenarios plus randomized traffic against an array-based model.
module tb_reg_file_sb;
  import rf_pkg::*;

  localparam int XLEN = 32;
  localparam int NREG = 16;
  localparam int AW   = 5;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            wr_en, iss_en, flush;
  logic [AW-1:0]   wr_addr, iss_addr, rd_addr1, rd_addr2;
  logic [XLEN-1:0] wr_data;
  logic            ready, busy1, busy2;
  logic [XLEN-1:0] rd_data1, rd_data2;
  rf_state_t       state;

  logic            ready32, busy1_32, busy2_32;
  logic [XLEN-1:0] rd_data1_32, rd_data2_32;
  rf_state_t       state32;

  reg_file_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
    .clk(clk), .reset(reset), .ready_o(ready),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_addr1_i(rd_addr1), .rd_addr2_i(rd_addr2),
    .rd_data1_o(rd_data1), .rd_data2_o(rd_data2),
    .rd_busy1_o(busy1), .rd_busy2_o(busy2),
    .iss_en_i(iss_en), .iss_addr_i(iss_addr), .flush_i(flush),
    .dbg_state(state)
  );

  reg_file_sb #(.XLEN(XLEN), .NREG(NREG_RV32I), .AW(AW)) dut32 (
    .clk(clk), .reset(reset), .ready_o(ready32),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_addr1_i(rd_addr1), .rd_addr2_i(rd_addr2),
    .rd_data1_o(rd_data1_32), .rd_data2_o(rd_data2_32),
    .rd_busy1_o(busy1_32), .rd_busy2_o(busy2_32),
    .iss_en_i(iss_en), .iss_addr_i(iss_addr), .flush_i(flush),
    .dbg_state(state32)
  );

  int errors = 0;
  int checks = 0;
  logic [XLEN-1:0] exp_q[$];

  // reference model: architectural contents, pending producers, cycles since reset release
  logic [XLEN-1:0] m_regs [NREG];
  bit              m_busy [NREG];
  bit              m_ready;
  int              m_cnt;

  function automatic bit addr_ok(input int a);
    return (a != 0) && (a < NREG);
  endfunction

  function automatic logic [XLEN-1:0] exp_rd(input int a);
    if (!(m_ready && reset)) return '0;
    if (!addr_ok(a)) return '0;
    if (wr_en && int'(wr_addr) == a) return wr_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (!(m_ready && reset)) return 1'b0;
    if (!addr_ok(a)) return 1'b0;
    return m_busy[a] && !(wr_en && int'(wr_addr) == a);
  endfunction

  task automatic model_edge();
    if (!reset) begin
      m_ready = 0;
      m_cnt   = 0;
      for (int i = 0; i < NREG; i++) begin
        m_busy[i] = 0;
        m_regs[i] = '0;
      end
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == NREG - 1) m_ready = 1;
    end else begin
      if (wr_en && addr_ok(int'(wr_addr))) m_regs[wr_addr] = wr_data;
      if (flush) begin
        for (int i = 0; i < NREG; i++) m_busy[i] = 0;
      end else begin
        if (wr_en && addr_ok(int'(wr_addr))) m_busy[wr_addr] = 0;
        if (iss_en && addr_ok(int'(iss_addr))) m_busy[iss_addr] = 1;
      end
    end
  endtask

  // driver tasks
  task automatic go();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = 0; wr_addr = '0; wr_data = '0;
    iss_en = 0; iss_addr = '0; flush = 0;
    rd_addr1 = '0; rd_addr2 = '0;
  endtask

  task automatic run_clear(input bit poke_x5);
    for (int c = 0; c < 33; c++) begin
      idle();
      rd_addr1 = 5'($urandom_range(1, NREG - 1));
      if (poke_x5 && c == 8) begin
        wr_en = 1; wr_addr = 5'd5; wr_data = 32'hDEAD;
      end
      #1;
      checks += 3;
      if (ready !== (c >= NREG - 1)) begin
        errors++; $display("FAIL clear_ready16 c=%0d: got %b expected %b", c, ready, c >= NREG - 1);
      end
      if (ready32 !== (c >= NREG_RV32I - 1)) begin
        errors++; $display("FAIL clear_ready32 c=%0d: got %b expected %b", c, ready32, c >= NREG_RV32I - 1);
      end
      if (rd_data1 !== exp_rd(int'(rd_addr1))) begin
        errors++; $display("FAIL clear_read c=%0d: got %h expected %h", c, rd_data1, exp_rd(int'(rd_addr1)));
      end
      go();
    end
    idle();
  endtask

  task automatic test_reset();
    idle();
    reset = 0;
    rd_addr1 = 5'd3;
    repeat (3) go();
    #1;
    checks += 4;
    if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
    if (rd_data1 !== '0) begin errors++; $display("FAIL reset_rd: got %h expected 0", rd_data1); end
    if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy1); end
    if (state !== CLEAR) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state, CLEAR); end
    reset = 1;
    run_clear(1'b1);
    #1;
    checks++;
    if (state !== READY) begin errors++; $display("FAIL ready_state: got %0d expected %0d", state, READY); end
  endtask

  task automatic test_clear_reads();
    for (int a = 1; a < NREG; a++) begin
      rd_addr1 = 5'(a);
      rd_addr2 = 5'(NREG - a);
      #1;
      checks += 2;
      if (rd_data1 !== '0) begin errors++; $display("FAIL cleared_x%0d: got %h expected 0", a, rd_data1); end
      if (rd_data2 !== '0) begin errors++; $display("FAIL cleared_x%0d: got %h expected 0", NREG - a, rd_data2); end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_write_read();
    idle();
    wr_en = 1; wr_addr = 5'd3; wr_data = 32'h12345678;
    go();
    wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rd_addr2 = 5'd0;
    #1;
    checks++;
    if (rd_data2 !== '0) begin errors++; $display("FAIL x0_bypass: got %h expected 0", rd_data2); end
    go();
    idle();
    rd_addr1 = 5'd3; rd_addr2 = 5'd0;
    #1;
    checks += 2;
    if (rd_data1 !== 32'h12345678) begin errors++; $display("FAIL write_x3: got %h expected 12345678", rd_data1); end
    if (rd_data2 !== '0) begin errors++; $display("FAIL read_x0: got %h expected 0", rd_data2); end
  endtask

  task automatic test_bypass();
    idle();
    wr_en = 1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
    rd_addr1 = 5'd7; rd_addr2 = 5'd20;
    #1;
    checks += 2;
    if (rd_data1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass_x7: got %h expected a5a5a5a5", rd_data1); end
    if (rd_data2 !== '0) begin errors++; $display("FAIL out_of_range: got %h expected 0", rd_data2); end
    go();
    idle();
    rd_addr1 = 5'd7; rd_addr2 = 5'd7;
    #1;
    checks += 2;
    if (rd_data1 !== 32'hA5A5A5A5) begin errors++; $display("FAIL stored_x7_p1: got %h expected a5a5a5a5", rd_data1); end
    if (rd_data2 !== 32'hA5A5A5A5) begin errors++; $display("FAIL stored_x7_p2: got %h expected a5a5a5a5", rd_data2); end
  endtask

  task automatic test_scoreboard();
    idle();
    iss_en = 1; iss_addr = 5'd4; rd_addr1 = 5'd4;
    #1;
    checks++;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL issue_same_cycle: got %b expected 0", busy1); end
    go();
    idle(); rd_addr1 = 5'd4;
    #1;
    checks++;
    if (busy1 !== 1'b1) begin errors++; $display("FAIL issued_x4: got %b expected 1", busy1); end
    wr_en = 1; wr_addr = 5'd4; wr_data = 32'h0BADF00D;
    #1;
    checks += 2;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL wb_mask_x4: got %b expected 0", busy1); end
    if (rd_data1 !== 32'h0BADF00D) begin errors++; $display("FAIL wb_bypass_x4: got %h expected 0badf00d", rd_data1); end
    go();
    idle(); rd_addr1 = 5'd4;
    #1;
    checks++;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL retired_x4: got %b expected 0", busy1); end
    wr_en = 1; wr_addr = 5'd4; wr_data = 32'h1; iss_en = 1; iss_addr = 5'd4;
    go();
    idle(); rd_addr1 = 5'd4;
    iss_en = 1; iss_addr = 5'd0;
    go();
    idle(); rd_addr1 = 5'd4; rd_addr2 = 5'd0;
    #1;
    checks += 2;
    if (busy1 !== 1'b1) begin errors++; $display("FAIL wb_and_issue_x4: got %b expected 1", busy1); end
    if (busy2 !== 1'b0) begin errors++; $display("FAIL issue_x0: got %b expected 0", busy2); end
    wr_en = 1; wr_addr = 5'd4; wr_data = 32'h2;
    go();
    idle();
  endtask

  task automatic test_flush();
    idle();
    iss_en = 1;
    iss_addr = 5'd2;  go();
    iss_addr = 5'd9;  go();
    iss_addr = 5'd11; go();
    idle(); rd_addr1 = 5'd2; rd_addr2 = 5'd9;
    #1;
    checks += 2;
    if (busy1 !== 1'b1) begin errors++; $display("FAIL issued_x2: got %b expected 1", busy1); end
    if (busy2 !== 1'b1) begin errors++; $display("FAIL issued_x9: got %b expected 1", busy2); end
    flush = 1; iss_en = 1; iss_addr = 5'd6;
    go();
    idle();
    for (int k = 0; k < 2; k++) begin
      rd_addr1 = (k == 0) ? 5'd2 : 5'd11;
      rd_addr2 = (k == 0) ? 5'd9 : 5'd6;
      #1;
      checks += 2;
      if (busy1 !== 1'b0) begin errors++; $display("FAIL flush_x%0d: got %b expected 0", rd_addr1, busy1); end
      if (busy2 !== 1'b0) begin errors++; $display("FAIL flush_x%0d: got %b expected 0", rd_addr2, busy2); end
    end
  endtask

  task automatic test_reset_mid();
    idle();
    reset = 0; go();
    reset = 1;
    for (int c = 0; c < 8; c++) go();
    reset = 0;
    #1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL mid_clear_ready: got %b expected 0", ready); end
    go();
    reset = 1;
    run_clear(1'b0);
    iss_en = 1; iss_addr = 5'd3; go();
    iss_addr = 5'd5; go();
    idle(); rd_addr1 = 5'd3; rd_addr2 = 5'd5;
    #1;
    checks++;
    if ({busy1, busy2} !== 2'b11) begin errors++; $display("FAIL pre_reset_busy: got %b expected 11", {busy1, busy2}); end
    reset = 0;
    #1;
    checks += 2;
    if (ready !== 1'b0) begin errors++; $display("FAIL ready_reset_ready: got %b expected 0", ready); end
    if ({busy1, busy2} !== 2'b00) begin errors++; $display("FAIL ready_reset_busy: got %b expected 00", {busy1, busy2}); end
    go();
    reset = 1;
    run_clear(1'b0);
    rd_addr1 = 5'd3; rd_addr2 = 5'd5;
    #1;
    checks++;
    if ({busy1, busy2} !== 2'b00) begin errors++; $display("FAIL post_reset_busy: got %b expected 00", {busy1, busy2}); end
  endtask

  task automatic test_random();
    logic [XLEN-1:0] e;
    for (int n = 0; n < 300; n++) begin
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = 5'($urandom_range(0, 19));
      wr_data  = $urandom;
      iss_en   = 1'($urandom_range(0, 1));
      iss_addr = 5'($urandom_range(0, 19));
      flush    = ($urandom_range(0, 15) == 0);
      rd_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 19));
      rd_addr2 = 5'($urandom_range(0, 19));
      #1;
      exp_q.push_back(exp_rd(int'(rd_addr1)));
      exp_q.push_back(exp_rd(int'(rd_addr2)));
      e = exp_q.pop_front();
      checks++;
      if (rd_data1 !== e) begin errors++; $display("FAIL rand_rd1 n=%0d a=%0d: got %h expected %h", n, rd_addr1, rd_data1, e); end
      e = exp_q.pop_front();
      checks++;
      if (rd_data2 !== e) begin errors++; $display("FAIL rand_rd2 n=%0d a=%0d: got %h expected %h", n, rd_addr2, rd_data2, e); end
      checks += 2;
      if (busy1 !== exp_busy(int'(rd_addr1))) begin
        errors++; $display("FAIL rand_busy1 n=%0d a=%0d: got %b expected %b", n, rd_addr1, busy1, exp_busy(int'(rd_addr1)));
      end
      if (busy2 !== exp_busy(int'(rd_addr2))) begin
        errors++; $display("FAIL rand_busy2 n=%0d a=%0d: got %b expected %b", n, rd_addr2, busy2, exp_busy(int'(rd_addr2)));
      end
      go();
    end
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    reset = 0;
    idle();
    @(negedge clk);
    test_reset();
    test_clear_reads();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
